wb_cmd_master_16: RTL and testbench

WB_CMD_MASTER_16 -- requirements
Module: wb_cmd_master_16

---
 rtl/wb_cmd_master_16.sv | 189 ++++++++++++++++++
 tb/tb_wb_cmd_master_16.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_16.sv
// Wishbone classic command master: accepts one write/read/poll command at a
// time, runs the bus cycle(s) with an ack timeout, and returns one response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid is high and
// ready is low. cmd_ready is high only in IDLE; rsp_valid only in RESP.
module wb_cmd_master_16 #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 1024,
    parameter int POLL_MAX     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [DATA_WIDTH-1:0]   cmd_mask,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_err,
    // Wishbone classic master port
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic                    wbm_we_o,
    output logic [SELECT_WIDTH-1:0] wbm_sel_o,
    output logic                    wbm_stb_o,
    input  logic                    wbm_ack_i,
    output logic                    wbm_cyc_o,
    // current FSM state, for observation only
    output logic [1:0]              dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // latched command
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [SELECT_WIDTH-1:0] sel_q;

    // cycles spent in the current bus cycle, and poll reads already completed
    logic [TW-1:0]           tmo_cnt;
    logic [PW-1:0]           poll_cnt;

    // held response
    logic [DATA_WIDTH-1:0]   rsp_dat_q;
    logic                    rsp_err_q;

    logic accept;
    logic poll_match;
    logic tmo_hit;
    logic last_read;

    assign accept     = cmd_valid && (state == IDLE) && !rst;
    assign poll_match = ((wbm_dat_i ^ dat_q) & mask_q) == '0;
    // Last permitted BUS cycle; an ack arriving here still wins over timeout.
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    assign last_read  = (poll_cnt == PW'(POLL_MAX - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: ack has priority over timeout; poll mismatches loop via GAP.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (cmd_op == OP_RSVD) ? RESP : BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    if ((op_q == OP_POLL) && !poll_match && !last_read) begin
                        next_state = GAP;
                    end else begin
                        next_state = RESP;
                    end
                end else if (tmo_hit) begin
                    next_state = RESP;
                end
            end
            GAP: begin
                next_state = BUS;
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latch, counters and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            mask_q    <= '0;
            sel_q     <= '0;
            tmo_cnt   <= '0;
            poll_cnt  <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op;
                        adr_q     <= cmd_adr;
                        dat_q     <= cmd_dat;
                        mask_q    <= cmd_mask;
                        sel_q     <= cmd_sel;
                        tmo_cnt   <= '0;
                        poll_cnt  <= '0;
                        rsp_dat_q <= '0;
                        rsp_err_q <= (cmd_op == OP_RSVD);
                    end
                end
                BUS: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (wbm_ack_i) begin
                        poll_cnt  <= poll_cnt + PW'(1);
                        rsp_dat_q <= (op_q == OP_WRITE) ? '0 : wbm_dat_i;
                        rsp_err_q <= (op_q == OP_POLL) && !poll_match && last_read;
                    end else if (tmo_hit) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                    end
                end
                GAP: begin
                    tmo_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; bus signals are driven only while in BUS.
    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
        rsp_dat   = (state == RESP) ? rsp_dat_q : '0;
        rsp_err   = (state == RESP) ? rsp_err_q : 1'b0;
        wbm_cyc_o = (state == BUS);
        wbm_stb_o = (state == BUS);
        wbm_we_o  = (state == BUS) && (op_q == OP_WRITE);
        wbm_adr_o = (state == BUS) ? adr_q : '0;
        wbm_sel_o = (state == BUS) ? sel_q : '0;
        wbm_dat_o = ((state == BUS) && (op_q == OP_WRITE)) ? dat_q : '0;
        dbg_state = state;
    end

endmodule

// File: tb/tb_wb_cmd_master_16.sv
// Testbench for wb_cmd_master_16: directed and randomized commands against a
// queue-driven Wishbone slave and a transaction-level expected-result model.
module tb_wb_cmd_master_16;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int SW    = 2;
    localparam int TMO   = 16;
    localparam int PM    = 4;
    localparam int NEVER = 1000000;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat, cmd_mask;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic          wbm_we_o, wbm_stb_o, wbm_ack_i, wbm_cyc_o;
    logic [SW-1:0] wbm_sel_o;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    wb_cmd_master_16 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW),
        .TIMEOUT(TMO), .POLL_MAX(PM)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_mask(cmd_mask), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
        .wbm_ack_i(wbm_ack_i), .wbm_cyc_o(wbm_cyc_o), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [DW:0]   exp_q[$];          // {err, dat} expected responses
    int            plan_delay[$];     // per-read ack delay (>= TMO means never)
    logic [DW-1:0] plan_data[$];      // per-read slave data
    int            sl_delay_q[$];
    logic [DW-1:0] sl_data_q[$];
    bit            noise_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- Wishbone slave ----------------
    // Acks a bus cycle after the planned number of wait cycles; outside a bus
    // cycle it may raise spurious acks, which the master must ignore.
    initial begin
        int            cnt;
        int            dly;
        bit            busy;
        logic [DW-1:0] d;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        cnt = 0; dly = 0; busy = 1'b0; d = '0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    if (sl_delay_q.size() > 0) begin
                        dly = sl_delay_q.pop_front();
                        d   = sl_data_q.pop_front();
                    end else begin
                        dly = NEVER;
                        d   = '0;
                    end
                end
                wbm_ack_i = (cnt == dly);
                wbm_dat_i = (cnt == dly) ? d : DW'($urandom);
                cnt++;
            end else begin
                busy      = 1'b0;
                wbm_ack_i = noise_en && ($urandom_range(0, 3) == 0);
                wbm_dat_i = DW'($urandom);
            end
        end
    end

    // ---------------- driver: one full command ----------------
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [DW-1:0] mask,
                           input logic [SW-1:0] sel, input int hold, input string tag);
        int            exp_reads, exp_stb, n_reads, n_stb, waited, gap_run;
        int            bad_fields, bad_gap, bad_hold;
        bit            exp_err, prev_stb, lat_ok;
        logic [DW-1:0] exp_dat;
        logic [DW:0]   got_rsp, exp_rsp;

        // Reference: walk the planned slave behaviour read by read.
        exp_err = 1'b0; exp_dat = '0; exp_reads = 0; exp_stb = 0;
        if (op == 2'd3) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < plan_delay.size(); i++) begin
                exp_reads++;
                if (plan_delay[i] >= TMO) begin
                    exp_stb += TMO; exp_err = 1'b1; exp_dat = '0;
                    break;
                end
                exp_stb += plan_delay[i] + 1;
                if (op == 2'd0) break;
                exp_dat = plan_data[i];
                if (op == 2'd1) break;
                if ((plan_data[i] & mask) == (dat & mask)) break;
                if (exp_reads == PM) begin
                    exp_err = 1'b1;
                    break;
                end
            end
        end
        exp_q.push_back({exp_err, exp_dat});
        sl_delay_q.delete();
        sl_data_q.delete();
        for (int i = 0; i < exp_reads; i++) begin
            sl_delay_q.push_back(plan_delay[i]);
            sl_data_q.push_back(plan_data[i]);
        end

        // Command handshake.
        cmd_op = op; cmd_adr = adr; cmd_dat = dat; cmd_mask = mask; cmd_sel = sel;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(negedge clk);
        // Scramble the command bus so only latched values can appear on the bus.
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_adr = AW'($urandom); cmd_dat = DW'($urandom);
        cmd_mask = DW'($urandom); cmd_sel = SW'($urandom);
        check({tag, "_busy"}, cmd_ready, 0);
        lat_ok = (op == 2'd3) ? (rsp_valid && !wbm_stb_o) : (wbm_stb_o && wbm_cyc_o);
        check({tag, "_accept_lat"}, lat_ok, 1);

        // Observe the bus until the response appears.
        n_reads = 0; n_stb = 0; prev_stb = 1'b0; gap_run = 0;
        bad_fields = 0; bad_gap = 0; waited = 0;
        while (!rsp_valid && waited < PM * (TMO + 2) + 10) begin
            if (wbm_cyc_o !== wbm_stb_o) bad_fields++;
            if (wbm_stb_o) begin
                if (!prev_stb) begin
                    n_reads++;
                    if (n_reads > 1 && gap_run != 1) bad_gap++;
                end
                n_stb++;
                if (wbm_adr_o !== adr || wbm_sel_o !== sel || wbm_we_o !== (op == 2'd0)) bad_fields++;
                if (op == 2'd0 && wbm_dat_o !== dat) bad_fields++;
                gap_run = 0;
            end else begin
                gap_run++;
            end
            prev_stb = wbm_stb_o;
            @(negedge clk);
            waited++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_end_lat"}, {prev_stb, wbm_stb_o}, (op == 2'd3) ? 2'b00 : 2'b10);
        check({tag, "_stb_cycles"}, n_stb, exp_stb);
        check({tag, "_bus_cycles"}, n_reads, exp_reads);
        check({tag, "_bus_fields"}, bad_fields, 0);
        check({tag, "_gaps"}, bad_gap, 0);
        got_rsp = {rsp_err, rsp_dat};
        exp_rsp = exp_q.pop_front();
        check({tag, "_rsp"}, got_rsp, exp_rsp);

        // Back-pressure: the response must hold until accepted.
        bad_hold = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_err, rsp_dat} !== got_rsp) bad_hold++;
        end
        check({tag, "_rsp_hold"}, bad_hold, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    function automatic logic [31:0] all_outputs();
        return {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} |
               32'(rsp_dat) | 32'(wbm_adr_o) | 32'(wbm_dat_o) | 32'(wbm_sel_o);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]    op;
        logic [DW-1:0] d, m;
        int            r, bad;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_dat = '0;
        cmd_mask = '0; cmd_sel = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", cmd_ready, 1);

        plan_delay = '{2};             plan_data = '{16'h0};
        run_cmd(2'd0, 3'd3, 16'h0063, 16'h0, 2'b11, 0, "write");
        plan_delay = '{0};             plan_data = '{16'h00A5};
        run_cmd(2'd1, 3'd0, 16'h0, 16'h0, 2'b11, 5, "read");
        plan_delay = '{1, 0, 2, 0};    plan_data = '{16'h1, 16'h1, 16'h1, 16'h0};
        run_cmd(2'd2, 3'd0, 16'h0, 16'h0001, 2'b11, 1, "poll_match4");
        plan_delay = '{0, 1, 0, 3};    plan_data = '{16'h1, 16'h1, 16'h1, 16'h1};
        run_cmd(2'd2, 3'd5, 16'h0, 16'h0001, 2'b01, 0, "poll_exhaust");
        plan_delay = '{NEVER};         plan_data = '{16'h0};
        run_cmd(2'd1, 3'd2, 16'h0, 16'h0, 2'b10, 0, "timeout");
        plan_delay = '{0};             plan_data = '{16'h0};
        run_cmd(2'd0, 3'd6, 16'hBEEF, 16'h0, 2'b01, 0, "after_timeout");
        plan_delay = '{TMO - 1};       plan_data = '{16'h1234};
        run_cmd(2'd1, 3'd1, 16'h0, 16'h0, 2'b11, 0, "ack_at_limit");
        plan_delay = '{0};             plan_data = '{16'h0};
        run_cmd(2'd3, 3'd4, 16'hFFFF, 16'h0, 2'b11, 2, "reserved");
        plan_delay = '{0, 0, 0, 0};    plan_data = '{16'h5A5A, 16'h0, 16'h0, 16'h0};
        run_cmd(2'd2, 3'd7, 16'h0, 16'h0, 2'b11, 0, "poll_mask0");
        plan_delay = '{0, NEVER, 0, 0}; plan_data = '{16'h1, 16'h1, 16'h0, 16'h0};
        run_cmd(2'd2, 3'd3, 16'h0, 16'h0001, 2'b11, 0, "poll_timeout");

        // Randomized commands with spurious acks outside bus cycles.
        noise_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd3 && $urandom_range(0, 1) == 0) op = 2'd2;
            d = DW'($urandom);
            m = DW'($urandom) & DW'($urandom);
            plan_delay.delete();
            plan_data.delete();
            for (int i = 0; i < PM; i++) begin
                r = $urandom_range(0, 19);
                plan_delay.push_back((r == 0) ? NEVER : (r == 1) ? TMO - 1 : $urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) plan_data.push_back((d & m) | (DW'($urandom) & ~m));
                else                           plan_data.push_back(DW'($urandom));
            end
            run_cmd(op, AW'($urandom), d, m, SW'($urandom), $urandom_range(0, 3), "rand");
        end
        noise_en = 1'b0;

        // Reset in the middle of a bus cycle: no response may ever appear.
        sl_delay_q.delete(); sl_data_q.delete();
        sl_delay_q.push_back(NEVER); sl_data_q.push_back(16'h0);
        cmd_op = 2'd1; cmd_adr = 3'd5; cmd_sel = 2'b11; cmd_valid = 1'b1;
        r = 0;
        while (!cmd_ready && r < 50) begin
            @(negedge clk);
            r++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_in_bus", wbm_stb_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", all_outputs(), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (TMO + 4) begin
            @(negedge clk);
            if (rsp_valid || wbm_stb_o) bad++;
        end
        check("midrst_no_rsp", bad, 0);
        check("midrst_ready", cmd_ready, 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
